// File: rtl/cordic_pkg.sv
// Shared constants for the cordic cosine sharing logic: widths, default
// pipeline depth, tag width helper and a few IEEE-754 single constants.
package cordic_pkg;

    localparam int CORDIC_DW      = 32;
    localparam int CORDIC_LATENCY = 18;

    localparam logic [CORDIC_DW-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [CORDIC_DW-1:0] FP_HALF = 32'h3F00_0000;
    localparam logic [CORDIC_DW-1:0] FP_ONE  = 32'h3F80_0000;

    // A tag must be at least one bit wide even for two requesters.
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cordic_scheduler_if.sv
// Requester-side handshake bundle: per-requester operand valid/ready/data
// and per-requester result valid/ready with one shared result bus.
interface cordic_scheduler_if
    import cordic_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = CORDIC_DW
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after
// i_ptr, wrapping modulo N. Reports one-hot grant, its index and whether any.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter int N = 4,
    parameter int W = tag_width(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    int unsigned w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = (32'(i_ptr) + k) % N;
            if (!o_any && i_req[W'(w_pos)]) begin
                o_any             = 1'b1;
                o_grant[W'(w_pos)] = 1'b1;
                o_idx             = W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one fixed-latency pipelined cordic between NREQ requesters; a
// valid/tag shift register mirrors the cordic pipeline to route results back.
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = CORDIC_LATENCY,
    parameter int DW      = CORDIC_DW
) (
    input  logic                         clock,
    input  logic                         reset,
    cordic_scheduler_if.slave            bus,
    output logic                         cordic_aclr,
    output logic                         cordic_clk_en,
    output logic [DW-1:0]                cordic_dataa,
    input  logic [DW-1:0]                cordic_result,
    output logic [$clog2(LATENCY+1)-1:0] in_flight,
    output logic                         idle
);

    localparam int TAGW = tag_width(NREQ);
    localparam int CNTW = $clog2(LATENCY + 1);

    logic [LATENCY-1:0] r_vld_sr;
    logic [TAGW-1:0]    r_tag_sr [LATENCY];
    logic [TAGW-1:0]    r_rr_ptr;
    logic [CNTW-1:0]    r_in_flight;

    logic [NREQ-1:0]    w_grant;
    logic [TAGW-1:0]    w_grant_idx;
    logic               w_any;
    logic               w_head_vld;
    logic [TAGW-1:0]    w_head_tag;
    logic               w_stall;
    logic               w_retire;
    logic               w_accept;

    rr_arbiter #(
        .N (NREQ),
        .W (TAGW)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_any)
    );

    assign w_head_vld = r_vld_sr[LATENCY-1];
    assign w_head_tag = r_tag_sr[LATENCY-1];
    assign w_retire   = w_head_vld && bus.rsp_ready[w_head_tag];
    // A result nobody can take freezes the whole cordic so it stays on the bus.
    assign w_stall    = w_head_vld && !bus.rsp_ready[w_head_tag];

    assign cordic_aclr   = reset;
    assign cordic_clk_en = !w_stall && !reset;
    assign w_accept      = w_any && cordic_clk_en;

    assign bus.req_ready = w_accept ? w_grant : '0;
    assign bus.rsp_data  = cordic_result;

    always_comb begin
        cordic_dataa = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_accept && w_grant[i]) begin
                cordic_dataa = bus.req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            bus.rsp_valid[i] = !reset && w_head_vld && (w_head_tag == TAGW'(i));
        end
    end

    assign in_flight = r_in_flight;
    assign idle      = !reset && (r_in_flight == '0) && !(|bus.req_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_sr    <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_tag_sr[i] <= '0;
            end
            r_rr_ptr    <= '0;
            r_in_flight <= '0;
        end else if (cordic_clk_en) begin
            r_vld_sr    <= {r_vld_sr[LATENCY-2:0], w_accept};
            r_tag_sr[0] <= w_accept ? w_grant_idx : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_tag_sr[i] <= r_tag_sr[i-1];
            end
            if (w_accept) begin
                r_rr_ptr <= (w_grant_idx == TAGW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (w_accept && !w_retire) begin
                r_in_flight <= r_in_flight + 1'b1;
            end else if (!w_accept && w_retire) begin
                r_in_flight <= r_in_flight - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with a clk_en-gated stand-in cordic
// pipeline whose transfer function is known to the bench.
module tb_cordic_scheduler;
    import cordic_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 18;
    localparam int DW   = 32;
    localparam int CW   = $clog2(LAT + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          cordic_aclr;
    logic          cordic_clk_en;
    logic [DW-1:0] cordic_dataa;
    logic [DW-1:0] cordic_result;
    logic [CW-1:0] in_flight;
    logic          idle;

    cordic_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    cordic_scheduler #(
        .NREQ    (NREQ),
        .LATENCY (LAT),
        .DW      (DW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .cordic_aclr   (cordic_aclr),
        .cordic_clk_en (cordic_clk_en),
        .cordic_dataa  (cordic_dataa),
        .cordic_result (cordic_result),
        .in_flight     (in_flight),
        .idle          (idle)
    );

    always #5 clock = ~clock;

    // Stand-in transfer function: a bijection, so every operand has a unique result.
    function automatic logic [31:0] cos_model(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h3F60_A800;
    endfunction

    logic [DW-1:0] cpipe [LAT];
    always @(posedge clock) begin
        if (cordic_clk_en) begin
            cpipe[0] <= cordic_dataa;
            for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
        end
    end
    assign cordic_result = cos_model(cpipe[LAT-1]);

    int          n_vec = 0;
    int          n_err = 0;
    int          ncyc  = 0;
    int          if_model = 0;
    int          n_acc = 0;
    int          n_ret = 0;
    bit          t5_on = 1'b0;
    int          k5    = 0;
    int          lane_seq [NREQ];
    logic [39:0] exp_q [$];
    logic [31:0] sweep [11] = '{32'h0000_0000, 32'h3DCC_CCCD, 32'h3E4C_CCCD, 32'h3E99_999A,
                               32'h3ECC_CCCD, 32'h3F00_0000, 32'h3F19_999A, 32'h3F33_3333,
                               32'h3F4C_CCCD, 32'h3F66_6666, 32'h3F80_0000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int grant_index(input logic [NREQ-1:0] r);
        int g;
        g = 99;
        for (int i = 0; i < NREQ; i++) if (r[i]) g = i;
        return g;
    endfunction

    task automatic set_lane(input int i, input logic [31:0] v);
        bus.req_data[i*DW +: DW] = v;
    endtask

    task automatic refresh(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                lane_seq[i]++;
                set_lane(i, {4'h4, 4'(i), 24'(lane_seq[i])});
            end
        end
    endtask

    // Scoreboard: results must come back in global issue order to their issuer.
    task automatic observe();
        logic [39:0] e;
        int acc;
        int ret;
        acc = 0;
        ret = 0;
        if (!reset) check("in_flight", 32'(in_flight), 32'(if_model));
        check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
        check("rsp_onehot", 32'($countones(bus.rsp_valid) <= 1), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                ret++;
                n_ret++;
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_tag", 32'(i), 32'(e[39:32]));
                    check("rsp_data", bus.rsp_data, cos_model(e[31:0]));
                end
                if (t5_on) begin
                    check("t5_port", 32'(bus.rsp_valid), 32'h2);
                    if (k5 < 11) check("t5_value", bus.rsp_data, cos_model(sweep[k5]));
                    else check("t5_extra", 32'(k5), 32'd10);
                    k5++;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                exp_q.push_back({8'(i), bus.req_data[i*DW +: DW]});
                acc++;
                n_acc++;
            end
        end
        if (reset) begin
            exp_q.delete();
            if_model = 0;
        end else begin
            if_model = if_model + acc - ret;
        end
    endtask

    task automatic tick();
        #1 observe();
        @(posedge clock);
        #1;
        ncyc++;
        if (ncyc > 20000) begin
            $display("FAIL watchdog: cycles %0d limit %0d", ncyc, 20000);
            $fatal(1, "watchdog expired");
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        while (in_flight != 0 && n < 4*LAT) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        int n;
        int g;
        int maxif;
        int stale;
        int acc0;
        int ret0;
        bit stalled;
        logic [31:0] held;
        logic [NREQ-1:0] mask;

        for (int i = 0; i < NREQ; i++) lane_seq[i] = 0;
        held = '0;
        reset = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        for (int i = 0; i < NREQ; i++) set_lane(i, 32'h1111_1111 * (i + 1));

        // 1: reset state, then a single op on requester 0
        tick();
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_clk_en", 32'(cordic_clk_en), 32'd0);
        check("rst_aclr", 32'(cordic_aclr), 32'd1);
        check("rst_idle", 32'(idle), 32'd0);
        check("rst_dataa", cordic_dataa, 32'd0);
        check("rst_in_flight", 32'(in_flight), 32'd0);
        tick();
        reset = 1'b0;
        bus.req_valid = '0;
        #1;
        check("t1_idle_after_rst", 32'(idle), 32'd1);
        check("t1_aclr_low", 32'(cordic_aclr), 32'd0);
        set_lane(0, FP_HALF);
        bus.req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(bus.req_ready), 32'h1);
        check("t1_dataa", cordic_dataa, 32'h3F00_0000);
        tick();
        bus.req_valid = '0;
        n = 1;
        #1;
        check("t1_in_flight1", 32'(in_flight), 32'd1);
        while (!bus.rsp_valid[0] && n < 4*LAT) begin
            tick();
            n++;
        end
        check("t1_latency", 32'(n), 32'(LAT));
        check("t1_rsp_data", bus.rsp_data, 32'h3F60_9700);
        tick();
        #1;
        check("t1_in_flight0", 32'(in_flight), 32'd0);
        check("t1_idle", 32'(idle), 32'd1);

        // 2: full load, grant order and saturation
        do_reset();
        bus.req_valid = '1;
        maxif = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            g = grant_index(bus.req_ready);
            if (c < 8) check("t2_grant", 32'(g), 32'(c % 4));
            if (c >= LAT) check("t2_gapless", 32'(|bus.rsp_valid), 32'd1);
            if (32'(in_flight) > maxif) maxif = 32'(in_flight);
            mask = bus.req_valid & bus.req_ready;
            tick();
            refresh(mask);
        end
        check("t2_saturate", 32'(maxif), 32'(LAT));
        drain("t2_drain");

        // 3: backpressure on requester 2 for five cycles
        do_reset();
        bus.req_valid = '1;
        stalled = 1'b0;
        acc0 = n_acc;
        ret0 = n_ret;
        for (int c = 0; c < 60; c++) begin
            if (!stalled && c >= LAT + 2 && bus.rsp_valid[2]) begin
                stalled = 1'b1;
                bus.rsp_ready = 4'b1011;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    check("t3_clk_en", 32'(cordic_clk_en), 32'd0);
                    check("t3_req_ready", 32'(bus.req_ready), 32'd0);
                    check("t3_head", 32'(bus.rsp_valid), 32'h4);
                    if (s == 0) held = bus.rsp_data;
                    else check("t3_rsp_hold", bus.rsp_data, held);
                    tick();
                end
                bus.rsp_ready = '1;
            end else begin
                #1;
                mask = bus.req_valid & bus.req_ready;
                tick();
                refresh(mask);
            end
        end
        check("t3_stalled", 32'(stalled), 32'd1);
        drain("t3_drain");
        check("t3_returned", 32'(n_ret - ret0), 32'(n_acc - acc0));

        // 4: reset with ten ops in flight and one at the head
        do_reset();
        bus.req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            #1;
            mask = bus.req_valid & bus.req_ready;
            tick();
            refresh(mask);
        end
        bus.req_valid = '0;
        n = 0;
        while (bus.rsp_valid == '0 && n < 4*LAT) begin
            tick();
            n++;
        end
        check("t4_head_wait", 32'(n), 32'(LAT - 10));
        reset = 1'b1;
        bus.req_valid = '1;
        #1;
        check("t4_req_ready", 32'(bus.req_ready), 32'd0);
        check("t4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t4_clk_en", 32'(cordic_clk_en), 32'd0);
        check("t4_dataa", cordic_dataa, 32'd0);
        check("t4_aclr", 32'(cordic_aclr), 32'd1);
        check("t4_idle_rst", 32'(idle), 32'd0);
        tick();
        reset = 1'b0;
        bus.req_valid = '0;
        #1;
        check("t4_in_flight", 32'(in_flight), 32'd0);
        check("t4_idle", 32'(idle), 32'd1);
        stale = 0;
        for (int c = 0; c < 2*LAT; c++) begin
            tick();
            if (bus.rsp_valid != '0) stale++;
        end
        check("t4_no_stale", 32'(stale), 32'd0);

        // 5: sweep on requester 1 with bubbles
        do_reset();
        t5_on = 1'b1;
        k5 = 0;
        for (int k = 0; k < 11; k++) begin
            set_lane(1, sweep[k]);
            bus.req_valid = 4'b0010;
            #1;
            check("t5_ready", 32'(bus.req_ready), 32'h2);
            check("t5_dataa", cordic_dataa, sweep[k]);
            tick();
            bus.req_valid = '0;
            tick();
            tick();
        end
        drain("t5_drain");
        check("t5_count", 32'(k5), 32'd11);
        t5_on = 1'b0;

        // 6: fairness and pointer hold across idle cycles
        do_reset();
        bus.req_valid = 4'b0001;
        tick();
        tick();
        tick();
        bus.req_valid = 4'b1001;
        n = 0;
        #1;
        while (!bus.req_ready[3] && n < 2*NREQ) begin
            tick();
            n++;
        end
        check("t6_req3_wait", 32'(n), 32'd0);
        tick();
        bus.req_valid = 4'b0001;
        #1;
        check("t6_back_to_0", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        check("t6_grant2", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        for (int c = 0; c < 5; c++) tick();
        bus.req_valid = 4'b1001;
        #1;
        check("t6_ptr_hold", 32'(bus.req_ready), 32'h8);
        tick();
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
